param_seq_alu: RTL and testbench
================================

PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 Parameter WIDTH, default 5, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  an operation is presented on inp_A/inp_B/select.
REQ-005 in_ready  output  1  block will accept the presented operation this cycle.
REQ-006 inp_A  input  WIDTH  operand A.
REQ-007 inp_B  input  WIDTH  operand B.
REQ-008 select  input  3  opcode: 0 AND, 1 ADD, 2 OR, 3 XOR, 4 SUB, 5 SHL, 6 SHR, 7 MUL.
REQ-009 out_valid  output  1  result and flags are valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out  output  WIDTH  registered result.
REQ-012 carry_out  output  1  carry/borrow/shift-out/multiply-overflow flag.
REQ-013 overflow  output  1  signed two's-complement overflow flag.
REQ-014 zero  output  1  out equals zero.
REQ-015 negative  output  1  equals out[WIDTH-1].
REQ-016 busy  output  1  multi-cycle multiply in progress.

Function
REQ-017 FSM states: IDLE, MUL_RUN, DONE; any unencoded state returns to IDLE.
REQ-018 in_ready SHALL be 1 in IDLE, and in DONE only while out_ready is 1; 0 in MUL_RUN.
REQ-019 Acceptance = in_valid and in_ready on a rising edge; operands and opcode are captured at that edge and later input changes are ignored.
REQ-020 Opcodes 0-6: result and flags registered at the accepting edge; state goes to DONE; out_valid is 1 in the following cycle (latency 1).
REQ-021 Opcode 7: state goes to MUL_RUN; busy is 1; shift-add runs one partial product per cycle for WIDTH cycles; DONE entered on the WIDTH-th edge after acceptance.
REQ-022 DONE: out, flags and out_valid hold stable until out_ready is 1; with out_ready=1 and no acceptance, return to IDLE and drop out_valid.
REQ-023 DONE with out_ready=1 and in_valid=1: the new operation is accepted on the same edge (back-to-back; no bubble for opcodes 0-6).
REQ-024 ADD: out = (A+B) mod 2^WIDTH; carry_out = bit WIDTH of the sum; overflow = signed overflow.
REQ-025 SUB: out = (A-B) mod 2^WIDTH; carry_out = 1 iff A < B unsigned (borrow); overflow = signed overflow.
REQ-026 SHL/SHR: logical shift of A by B unsigned; carry_out = last bit shifted out; B = 0 gives carry_out 0; B >= WIDTH gives out 0, and carry_out is the last bit shifted out (0 when B > WIDTH).
REQ-027 MUL: out = low WIDTH bits of the unsigned product; carry_out = OR of the upper WIDTH product bits; overflow = 0.
REQ-028 AND/OR/XOR: carry_out = 0, overflow = 0.
REQ-029 zero and negative are derived from the registered out for every opcode.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, out = 0, all flags 0, out_valid 0, busy 0, and clear the multiply counter and accumulator.
REQ-031 Reset during MUL_RUN or DONE SHALL discard the operation; nothing is delivered after reset release.
REQ-032 in_ready SHALL be 1 from the first cycle after reset_n deasserts.

Structure
REQ-033 Shared package alu_pkg SHALL hold the opcode enumeration (3 bits), the FSM state enumeration and the default WIDTH constant.
REQ-034 The sequential shift-add multiplier SHALL be a sub-module seq_mul_unit (start, operands, done, product of 2*WIDTH bits); all other opcodes stay in the top.

Verification (WIDTH=5)
REQ-035 ADD A=20, B=15 -> out=3, carry_out=1, overflow=0, out_valid in the cycle after acceptance.
REQ-036 ADD A=15, B=1 -> out=16, overflow=1, negative=1; SUB A=3, B=5 -> out=30, carry_out=1.
REQ-037 MUL A=7, B=5 -> busy=1 for 5 cycles, in_ready=0 throughout, then out=3, carry_out=1, out_valid=1.
REQ-038 SHL A=5'b10011, B=2 -> out=5'b01100, carry_out=0; SHR A=5'b00011, B=5 -> out=0, carry_out=0.
REQ-039 Hold out_ready=0 for 4 cycles after an XOR result -> out and flags are stable and in_ready=0; then out_ready=1 with in_valid=1 (AND) -> accepted on the same edge.
REQ-040 reset_n pulsed low in the 3rd MUL_RUN cycle -> outputs 0 immediately, no out_valid after release, next ADD 1+1 -> out=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and default width for the sequential ALU.
// The multiply-opcode helper keeps the decode in one place.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 5;

   typedef enum logic [2:0] {
      OP_AND = 3'd0,
      OP_ADD = 3'd1,
      OP_OR  = 3'd2,
      OP_XOR = 3'd3,
      OP_SUB = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MUL = 3'd7
   } opcodeT;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MUL_RUN = 2'd1,
      ST_DONE    = 2'd2
   } stateT;

   function automatic logic isMulOp(input logic [2:0] sel);
      return opcodeT'(sel) == OP_MUL;
   endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// Unsigned shift-add multiplier: one partial product per clock, WIDTH steps.
// done/product are combinational on the final step so the caller registers them.
module seq_mul_unit #(
   parameter int WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 start,
   input  logic [WIDTH-1:0]     opA,
   input  logic [WIDTH-1:0]     opB,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] accReg;
   logic [2*WIDTH-1:0] mcandReg;
   logic [WIDTH-1:0]   mplierReg;
   logic [CNT_W-1:0]   countReg;
   logic               runReg;
   logic [2*WIDTH-1:0] ppTerm;
   logic [2*WIDTH-1:0] accNext;

   // Partial product: multiplicand gated by the current multiplier LSB.
   genvar gi;
   generate
      for (gi = 0; gi < 2*WIDTH; gi++) begin : g_pp
         assign ppTerm[gi] = mcandReg[gi] & mplierReg[0];
      end
   endgenerate

   assign accNext = accReg + ppTerm;
   assign done    = runReg && (countReg == CNT_W'(WIDTH-1));
   assign product = accNext;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         accReg    <= '0;
         mcandReg  <= '0;
         mplierReg <= '0;
         countReg  <= '0;
         runReg    <= 1'b0;
      end else if (start) begin
         accReg    <= '0;
         mcandReg  <= {{WIDTH{1'b0}}, opA};
         mplierReg <= opB;
         countReg  <= '0;
         runReg    <= 1'b1;
      end else if (runReg) begin
         accReg    <= accNext;
         mcandReg  <= mcandReg << 1;
         mplierReg <= mplierReg >> 1;
         countReg  <= countReg + CNT_W'(1);
         if (done)
            runReg <= 1'b0;
      end
   end

endmodule

// File: rtl/param_seq_alu.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, multi-cycle multiply,
// with results and flags held in DONE until the consumer takes them.
module param_seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inp_A,
   input  logic [WIDTH-1:0] inp_B,
   input  logic [2:0]       select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             busy
);

   localparam int MSB = WIDTH - 1;

   stateT              stateReg;
   logic [WIDTH-1:0]   outReg;
   logic               carryReg;
   logic               ovfReg;
   logic               zeroReg;
   logic               negReg;
   logic               validReg;
   logic               busyReg;

   opcodeT             opcode;
   logic               accept;
   logic               mulStart;
   logic               mulDone;
   logic [2*WIDTH-1:0] mulProduct;

   logic [WIDTH:0]     sumWide;
   logic [WIDTH:0]     diffWide;
   logic [WIDTH:0]     shlWide;
   logic [WIDTH:0]     shrWide;
   logic [WIDTH-1:0]   aluOut;
   logic               aluCarry;
   logic               aluOvf;
   logic [WIDTH-1:0]   mulOut;
   logic               mulCarry;

   assign opcode   = opcodeT'(select);
   assign in_ready = (stateReg == ST_IDLE) || ((stateReg == ST_DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign mulStart = accept && isMulOp(select);

   // Bit WIDTH of each widened result is the carry, borrow or shifted-out bit.
   assign sumWide  = {1'b0, inp_A} + {1'b0, inp_B};
   assign diffWide = {1'b0, inp_A} - {1'b0, inp_B};
   assign shlWide  = {1'b0, inp_A} << inp_B;
   assign shrWide  = {inp_A, 1'b0} >> inp_B;

   always_comb begin
      aluOut   = '0;
      aluCarry = 1'b0;
      aluOvf   = 1'b0;
      case (opcode)
         OP_AND: aluOut = inp_A & inp_B;
         OP_OR:  aluOut = inp_A | inp_B;
         OP_XOR: aluOut = inp_A ^ inp_B;
         OP_ADD: begin
            aluOut   = sumWide[MSB:0];
            aluCarry = sumWide[WIDTH];
            aluOvf   = (inp_A[MSB] == inp_B[MSB]) && (sumWide[MSB] != inp_A[MSB]);
         end
         OP_SUB: begin
            aluOut   = diffWide[MSB:0];
            aluCarry = diffWide[WIDTH];
            aluOvf   = (inp_A[MSB] != inp_B[MSB]) && (diffWide[MSB] != inp_A[MSB]);
         end
         OP_SHL: begin
            aluOut   = shlWide[MSB:0];
            aluCarry = shlWide[WIDTH];
         end
         OP_SHR: begin
            aluOut   = shrWide[WIDTH:1];
            aluCarry = shrWide[0];
         end
         default: begin
            aluOut   = '0;
            aluCarry = 1'b0;
         end
      endcase
   end

   assign mulOut   = mulProduct[MSB:0];
   assign mulCarry = |mulProduct[2*WIDTH-1:WIDTH];

   seq_mul_unit #(
      .WIDTH(WIDTH)
   ) uMul (
      .clk     (clk),
      .resetN  (reset_n),
      .start   (mulStart),
      .opA     (inp_A),
      .opB     (inp_B),
      .done    (mulDone),
      .product (mulProduct)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateReg <= ST_IDLE;
         outReg   <= '0;
         carryReg <= 1'b0;
         ovfReg   <= 1'b0;
         zeroReg  <= 1'b0;
         negReg   <= 1'b0;
         validReg <= 1'b0;
         busyReg  <= 1'b0;
      end else begin
         case (stateReg)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (isMulOp(select)) begin
                     stateReg <= ST_MUL_RUN;
                     busyReg  <= 1'b1;
                     validReg <= 1'b0;
                  end else begin
                     stateReg <= ST_DONE;
                     outReg   <= aluOut;
                     carryReg <= aluCarry;
                     ovfReg   <= aluOvf;
                     zeroReg  <= (aluOut == '0);
                     negReg   <= aluOut[MSB];
                     validReg <= 1'b1;
                  end
               end else if ((stateReg == ST_DONE) && out_ready) begin
                  stateReg <= ST_IDLE;
                  validReg <= 1'b0;
               end
            end
            ST_MUL_RUN: begin
               if (mulDone) begin
                  stateReg <= ST_DONE;
                  busyReg  <= 1'b0;
                  outReg   <= mulOut;
                  carryReg <= mulCarry;
                  ovfReg   <= 1'b0;
                  zeroReg  <= (mulOut == '0);
                  negReg   <= mulOut[MSB];
                  validReg <= 1'b1;
               end
            end
            default: begin
               stateReg <= ST_IDLE;
               validReg <= 1'b0;
               busyReg  <= 1'b0;
            end
         endcase
      end
   end

   assign out       = outReg;
   assign carry_out = carryReg;
   assign overflow  = ovfReg;
   assign zero      = zeroReg;
   assign negative  = negReg;
   assign out_valid = validReg;
   assign busy      = busyReg;

endmodule

// File: tb/tb_param_seq_alu.sv
// Directed plus randomized bench for param_seq_alu (WIDTH=5) against an
// arithmetic reference model of the opcode rules.
module tb_param_seq_alu;

   localparam int W = 5;

   logic         clk;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] inp_A;
   logic [W-1:0] inp_B;
   logic [2:0]   select;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         carry_out;
   logic         overflow;
   logic         zero;
   logic         negative;
   logic         busy;

   int total = 0;
   int bad   = 0;

   param_seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inp_A     (inp_A),
      .inp_B     (inp_B),
      .select    (select),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int toSigned(input int v);
      return (v >= (1 << (W-1))) ? v - (1 << W) : v;
   endfunction

   // Reference: plain integer arithmetic following the opcode rules.
   function automatic void refAlu(input int op, input int a, input int b,
                                  output int r, output int c, output int v);
      int mask;
      int s;
      int maxS;
      int minS;
      mask = (1 << W) - 1;
      maxS = (1 << (W-1)) - 1;
      minS = -(1 << (W-1));
      r = 0; c = 0; v = 0;
      case (op)
         0: r = a & b;
         1: begin
            s = a + b;
            r = s & mask;
            c = (s > mask) ? 1 : 0;
            s = toSigned(a) + toSigned(b);
            v = (s > maxS || s < minS) ? 1 : 0;
         end
         2: r = a | b;
         3: r = a ^ b;
         4: begin
            r = (a - b) & mask;
            c = (a < b) ? 1 : 0;
            s = toSigned(a) - toSigned(b);
            v = (s > maxS || s < minS) ? 1 : 0;
         end
         5: begin
            r = (b >= W) ? 0 : ((a << b) & mask);
            c = (b >= 1 && b <= W) ? ((a >> (W - b)) & 1) : 0;
         end
         6: begin
            r = (b >= W) ? 0 : (a >> b);
            c = (b >= 1 && b <= W) ? ((a >> (b - 1)) & 1) : 0;
         end
         default: begin
            s = a * b;
            r = s & mask;
            c = ((s >> W) != 0) ? 1 : 0;
         end
      endcase
   endfunction

   // Presents one operation, waits for its result and checks it; leaves the
   // block in DONE with out_ready low.
   task automatic runOp(input int op, input int a, input int b, output int oOut);
      int n;
      int eR, eC, eV;
      logic [31:0] rnd;
      refAlu(op, a, b, eR, eC, eV);
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", in_ready, 1);
      rnd = op;      select = rnd[2:0];
      rnd = a;       inp_A  = rnd[W-1:0];
      rnd = b;       inp_B  = rnd[W-1:0];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rnd = $urandom; inp_A  = rnd[W-1:0];
      rnd = $urandom; inp_B  = rnd[W-1:0];
      rnd = $urandom; select = rnd[2:0];
      n = 1;
      while (!out_valid && n < 100) begin
         if (op == 7) begin
            check("mul_busy", busy, 1);
            check("mul_in_ready", in_ready, 0);
         end
         @(negedge clk);
         n++;
      end
      check("latency", n, (op == 7) ? W + 1 : 1);
      check("out", out, eR);
      check("carry_out", carry_out, eC);
      check("overflow", overflow, eV);
      check("zero", zero, (eR == 0) ? 1 : 0);
      check("negative", negative, (eR >> (W-1)) & 1);
      check("busy_after", busy, 0);
      oOut = out;
      $display("op=%0d a=%0d b=%0d out=%0d carry=%0b ovf=%0b lat=%0d",
               op, a, b, out, carry_out, overflow, n);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("drain_valid", out_valid, 0);
   endtask

   int r;
   int seen;
   int op, a, b, hold;

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      inp_A     = '0;
      inp_B     = '0;
      select    = '0;
      repeat (2) @(negedge clk);
      check("rst_out", out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_carry", carry_out, 0);
      check("rst_ovf", overflow, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", in_ready, 1);

      runOp(1, 20, 15, r);
      check("add20_15_out", r, 3);
      check("add20_15_carry", carry_out, 1);
      drain();
      runOp(1, 15, 1, r);
      check("add15_1_ovf", overflow, 1);
      check("add15_1_neg", negative, 1);
      drain();
      runOp(4, 3, 5, r);
      check("sub3_5_out", r, 30);
      check("sub3_5_borrow", carry_out, 1);
      drain();
      runOp(7, 7, 5, r);
      check("mul7_5_out", r, 3);
      check("mul7_5_carry", carry_out, 1);
      drain();
      runOp(5, 5'b10011, 2, r);
      check("shl_out", r, 5'b01100);
      check("shl_carry", carry_out, 0);
      drain();
      runOp(6, 5'b00011, 5, r);
      check("shr5_out", r, 0);
      check("shr5_carry", carry_out, 0);
      drain();
      runOp(5, 5'b10101, 5, r); drain();
      runOp(6, 5'b10101, 5, r); drain();
      runOp(5, 5'b10101, 0, r); drain();
      runOp(6, 5'b11111, 6, r); drain();
      runOp(7, 31, 31, r);      drain();
      runOp(7, 0, 19, r);       drain();

      // Result held while the consumer stalls, with a new op already waiting.
      runOp(3, 5'b10110, 5'b01100, r);
      in_valid = 1'b1;
      select   = 3'd0;
      inp_A    = 5'd31;
      inp_B    = 5'd9;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("hold_out", out, 5'b11010);
         check("hold_valid", out_valid, 1);
         check("hold_carry", carry_out, 0);
         check("hold_neg", negative, 1);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      check("b2b_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_valid", out_valid, 1);
      check("b2b_out", out, 9);
      drain();

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 7);
         a  = $urandom_range(0, 31);
         b  = $urandom_range(0, 31);
         runOp(op, a, b, r);
         hold = $urandom_range(0, 2);
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rand_hold_valid", out_valid, 1);
         end
         drain();
      end

      // Reset in the third multiply cycle must discard the operation.
      runOp(1, 20, 15, r);
      drain();
      check("pre_rst_out", out, 3);
      select   = 3'd7;
      inp_A    = 5'd7;
      inp_B    = 5'd5;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_mul_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      check("async_rst_out", out, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_valid", out_valid, 0);
      check("async_rst_carry", carry_out, 0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("no_valid_after_rst", seen, 0);
      runOp(1, 1, 1, r);
      check("add1_1_out", r, 2);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
